count4_timer_ctrl: RTL and testbench

Sequencing controller for the 4-bit down-counter datapath: loads a start value, decrements it once per prescaled tick, and signals terminal count. Supports one-shot and auto-reload operation, pause and abort. Sits between software- or FSM-level requesters and the counter, so users issue a start handshake instead of driving counter clocks directly. Fully synchronous to one clock, unlike the ripple counter it sequences.

---
 rtl/count_timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/count4_timer_ctrl.sv | 116 +++++++++++
 tb/tb_count4_timer_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/count_timer_pkg.sv
// Shared definitions for the count4 timer controller: FSM state encoding and
// default datapath sizing.
package count_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-PRESCALE edge counter: emits a one-cycle tick on every PRESCALE-th
// enabled edge. With PRESCALE=1 the counter stays at 0 and tick follows enable.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= '0;
      else if (enable)
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/count4_timer_ctrl.sv
// Start/pause/abort sequencer around a down-counter: loads a start value,
// decrements on each prescaled tick and pulses done at terminal count.
module count4_timer_ctrl
   import count_timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state
);

   state_t           st_q, st_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rel_q, rel_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             presc_en, presc_clr, tick;

   // Abort is masked out of the enable so a coincident terminal tick is lost.
   assign presc_en = busy_q && !pause && !abort;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk    (clk),
      .reset  (reset),
      .enable (presc_en),
      .clear  (presc_clr),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q   <= ST_IDLE;
         cnt_q  <= '0;
         rel_q  <= '0;
         mode_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         rel_q  <= rel_d;
         mode_q <= mode_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      rel_d     = rel_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      presc_clr = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (start) begin
               presc_clr = 1'b1;
               if (load_val == '0) begin
                  done_d = 1'b1;
               end else begin
                  cnt_d  = load_val;
                  rel_d  = load_val;
                  mode_d = auto_reload;
                  st_d   = pause ? ST_PAUSE : ST_RUN;
               end
            end
         end
         ST_RUN, ST_PAUSE: begin
            if (abort) begin
               st_d      = ST_IDLE;
               cnt_d     = '0;
               presc_clr = 1'b1;
            end else begin
               st_d = pause ? ST_PAUSE : ST_RUN;
               if (tick) begin
                  if (cnt_q > WIDTH'(1)) begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end else begin
                     done_d = 1'b1;
                     if (mode_q) begin
                        cnt_d = rel_q;
                     end else begin
                        cnt_d = '0;
                        st_d  = ST_IDLE;
                     end
                  end
               end
            end
         end
         default: begin
            st_d      = ST_IDLE;
            cnt_d     = '0;
            presc_clr = 1'b1;
         end
      endcase
      busy_d = (st_d != ST_IDLE);
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign count = cnt_q;
   assign state = st_q;

endmodule

// File: tb/tb_count4_timer_ctrl.sv
// Scenario bench for count4_timer_ctrl: one instance with PRESCALE=1, one with
// PRESCALE=3; expected post-edge outputs are queued then compared after each edge.
module tb_count4_timer_ctrl;

   typedef struct packed {
      logic [3:0] count;
      logic       done;
      logic       busy;
      logic [1:0] state;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1, start3;
   logic [3:0] load_val;
   logic       auto_reload, pause, abort;
   logic       busy1, done1, busy3, done3;
   logic [3:0] count1, count3;
   logic [1:0] state1, state3;
   obs_t       obs1, obs3, e;
   obs_t       sb[$];
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   count4_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .load_val(load_val),
      .auto_reload(auto_reload), .pause(pause), .abort(abort),
      .busy(busy1), .done(done1), .count(count1), .state(state1)
   );

   count4_timer_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .load_val(load_val),
      .auto_reload(auto_reload), .pause(pause), .abort(abort),
      .busy(busy3), .done(done3), .count(count3), .state(state3)
   );

   assign obs1 = {count1, done1, busy1, state1};
   assign obs3 = {count3, done3, busy3, state3};

   function automatic obs_t mk(int c, bit d, bit b, int s);
      obs_t o;
      o.count = c[3:0];
      o.done  = d;
      o.busy  = b;
      o.state = s[1:0];
      return o;
   endfunction

   task automatic idle_inputs();
      start1 = 0; start3 = 0; load_val = 0;
      auto_reload = 0; pause = 0; abort = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      sb.push_back(mk(0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0));
      #3;
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) begin
         n_fail++; $display("FAIL reset_p1: got %h want %h", obs1, e);
      end
      e = sb.pop_front(); n_chk++;
      if (obs3 !== e) begin
         n_fail++; $display("FAIL reset_p3: got %h want %h", obs3, e);
      end
      #4 reset = 1'b0;
   endtask

   // P=1, N=5: count 5..1 then 0 with done after edge 5, busy low from edge 5.
   task automatic test_one_shot();
      for (int i = 0; i <= 6; i++) begin
         start1 = (i == 0); load_val = 4'd5;
         sb.push_back(mk((i <= 5) ? 5 - i : 0, i == 5, i < 5, (i < 5) ? 1 : 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) begin
            n_fail++; $display("FAIL one_shot edge %0d: got %h want %h", i, obs1, e);
         end
      end
      idle_inputs();
   endtask

   // P=3, N=2, pause sampled high at edges 2..5: done after edge 10.
   task automatic test_prescale_pause();
      for (int i = 0; i <= 11; i++) begin
         start3 = (i == 0); load_val = 4'd2;
         pause  = (i >= 2 && i <= 5);
         sb.push_back(mk((i <= 6) ? 2 : (i <= 9) ? 1 : 0, i == 10, i < 10,
                         (i >= 2 && i <= 5) ? 2 : (i < 10) ? 1 : 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs3 !== e) begin
            n_fail++; $display("FAIL prescale_pause edge %0d: got %h want %h", i, obs3, e);
         end
      end
      idle_inputs();
   endtask

   // P=1, N=3 periodic: done after edges 3,6,9; abort at edge 11 stops it.
   task automatic test_auto_reload();
      for (int i = 0; i <= 13; i++) begin
         start1 = (i == 0); load_val = 4'd3; auto_reload = 1'b1;
         abort  = (i == 11);
         if (i < 11)
            sb.push_back(mk(3 - (i % 3), (i > 0) && (i % 3 == 0), 1, 1));
         else
            sb.push_back(mk(0, 0, 0, 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) begin
            n_fail++; $display("FAIL auto_reload edge %0d: got %h want %h", i, obs1, e);
         end
      end
      idle_inputs();
   endtask

   task automatic test_zero_and_collisions();
      // zero load: single done pulse, never busy
      for (int i = 0; i <= 1; i++) begin
         start1 = (i == 0); load_val = 4'd0;
         sb.push_back(mk(0, i == 0, 0, 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) begin
            n_fail++; $display("FAIL zero_load edge %0d: got %h want %h", i, obs1, e);
         end
      end
      // start while busy is ignored; restart on the cycle after busy falls
      for (int i = 0; i <= 6; i++) begin
         start1 = (i == 0) || (i == 2) || (i == 5);
         load_val = (i == 0) ? 4'd4 : (i == 2) ? 4'd9 : 4'd1;
         auto_reload = (i == 2);
         if (i <= 4)      sb.push_back(mk(4 - i, i == 4, i < 4, (i < 4) ? 1 : 0));
         else if (i == 5) sb.push_back(mk(1, 0, 1, 1));
         else             sb.push_back(mk(0, 1, 0, 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) begin
            n_fail++; $display("FAIL busy_start edge %0d: got %h want %h", i, obs1, e);
         end
      end
      idle_inputs();
      // start+abort in IDLE: start wins; abort on terminal tick: no done
      for (int i = 0; i <= 3; i++) begin
         start1 = (i == 0); load_val = 4'd2;
         abort  = (i == 0) || (i == 2);
         if (i <= 1) sb.push_back(mk(2 - i, 0, 1, 1));
         else        sb.push_back(mk(0, 0, 0, 0));
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if (obs1 !== e) begin
            n_fail++; $display("FAIL abort_collide edge %0d: got %h want %h", i, obs1, e);
         end
      end
      idle_inputs();
   endtask

   // async reset between edges clears everything before the next edge
   task automatic test_reset_mid_run();
      start1 = 1'b1; load_val = 4'd9;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      sb.push_back(mk(8, 0, 1, 1));
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) begin
         n_fail++; $display("FAIL mid_run_pre: got %h want %h", obs1, e);
      end
      #2 reset = 1'b1;
      sb.push_back(mk(0, 0, 0, 0));
      #1;
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) begin
         n_fail++; $display("FAIL mid_run_reset: got %h want %h", obs1, e);
      end
      #2 reset = 1'b0;
      sb.push_back(mk(0, 0, 0, 0));
      @(posedge clk); #1;
      e = sb.pop_front(); n_chk++;
      if (obs1 !== e) begin
         n_fail++; $display("FAIL mid_run_after: got %h want %h", obs1, e);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_prescale_pause();
      test_auto_reload();
      test_zero_and_collisions();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
